sub_32b_serial: RTL and testbench

Multi-cycle 32-bit subtractor computing diff = a - b - bin, the inverse operation of the team's 32-bit ripple adder.
- Processes one 4-bit digit per clock, LSB digit first, through a single registered digit-subtractor slice. Carry (inverted borrow) is held in a flop between digits.
- Sits beside the adder in the datapath wherever area matters more than latency.
- Uses a valid/ready handshake on both input and output.

---
 rtl/sub_pkg.sv | 25 ++
 rtl/sub_4b.sv | 26 ++
 rtl/sub_32b_serial.sv | 134 +++++++++++++
 tb/tb_sub_32b_serial.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants, state type and helpers for the serial subtractor
//
// Purpose : default operand/digit sizes, digit count, counter width and FSM state type.
// Ports   : none (package).

package sub_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DIGIT_DEF  = 4;
  localparam int NUM_DIGITS = WIDTH_DEF / DIGIT_DEF;

  // Counter must index NUM digits; never narrower than one bit.
  function automatic int cnt_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int CNT_W = cnt_width(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_4b.sv
// rtl/sub_4b.sv - combinational one-digit subtract slice
//
// Purpose : computes {cout, d} = a + ~b + cin for one DIGIT-bit digit.
//           cin/cout are carries, i.e. inverted borrows.
// Ports   : a    - minuend digit
//           b    - subtrahend digit
//           cin  - carry in (1 = no borrow)
//           d    - difference digit
//           cout - carry out (1 = no borrow)

module sub_4b #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] d,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum       = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, cin};
  assign {cout, d} = sum;

endmodule

// File: rtl/sub_32b_serial.sv
// rtl/sub_32b_serial.sv - digit-serial subtractor, diff = a - b - bin, one digit per clock
//
// Purpose : captures operands in IDLE, runs WIDTH/DIGIT cycles through a single
//           sub_4b slice LSB digit first, then presents the result in DONE until
//           the consumer takes it.
// Config  : define SUB_OVERFLOW_EN to produce the signed overflow flag on ovf;
//           otherwise ovf is tied low.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - operand handshake
//           a, b, bin           - minuend, subtrahend, borrow in
//           out_valid/out_ready - result handshake
//           diff, bout, ovf     - difference, borrow out, signed overflow

module sub_32b_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = cnt_width(NUM);

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic [DIGIT-1:0] d;
  logic             cout;
  logic             last;

  assign last = (cnt == CW'(NUM - 1));

  // Operands are shifted right each RUN cycle so the slice always sees the
  // current digit in the low bits; no variable part-select is needed.
  sub_4b #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .d    (d),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b1;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ~bin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          // New digit enters at the top; after NUM shifts digit 0 sits at the bottom.
          diff_q <= {d, diff_q[WIDTH-1:DIGIT]};
          carry  <= cout;
          cnt    <= cnt + CW'(1);
          if (last) bout_q <= ~cout;
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SUB_OVERFLOW_EN
  logic ovf_q;

  // On the final digit the low bits of the shifted operands hold the top
  // digit, so bit DIGIT-1 is the original sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_q <= (a_sh[DIGIT-1] != b_sh[DIGIT-1]) && (d[DIGIT-1] != a_sh[DIGIT-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_32b_serial.sv
// tb/tb_sub_32b_serial.sv - self-checking bench for sub_32b_serial

module tb_sub_32b_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  sub_32b_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit unsigned arithmetic; the top bit is the borrow.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                       output logic [31:0] md, output logic mbo, output logic mov);
    logic [32:0] r;
    r   = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    md  = r[31:0];
    mbo = r[32];
`ifdef SUB_OVERFLOW_EN
    mov = (ma[31] != mb[31]) && (md[31] != ma[31]);
`else
    mov = 1'b0;
`endif
  endtask

  // Accept at a posedge, leave the bench at the negedge after it.
  task automatic accept(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                        input logic early_ready);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = early_ready;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns the number of negedges counted from the one after accept.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tbin, input logic early_ready);
    logic [31:0] ed;
    logic        eb, eo;
    int          cyc;
    model(ta, tb, tbin, ed, eb, eo);
    accept(ta, tb, tbin, early_ready);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
    chk({tag, "_diff_held_idle"}, diff, ed);
  endtask

  initial begin
    logic [31:0] ed, held;
    logic        eb, eo;
    int          cyc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_bout", bout, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    rst = 1'b0;

    run_op("small", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    run_op("zero_minus_one", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op("zero_borrow_in", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    run_op("digit_borrow", 32'h0000_0010, 32'h0000_000F, 1'b1, 1'b0);
    run_op("sign_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op("equal", 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 1'b1);

    // Backpressure: result must stay put while busy inputs are ignored.
    model(32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, ed, eb, eo);
    accept(32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, 1'b0);
    wait_done(cyc);
    chk("bp_latency", cyc, 8);
    held = diff;
    chk("bp_diff", held, ed);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = $urandom; b = $urandom; bin = i[1];
      @(negedge clk);
      chk("bp_diff_stable", diff, ed);
      chk("bp_bout_stable", bout, eb);
      chk("bp_flags", {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", {out_valid, in_ready}, 2'b01);
    chk("bp_diff_after", diff, ed);

    // Reset in the middle of RUN discards the operation.
    accept(32'h5555_5555, 32'h1111_1111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flags", {out_valid, in_ready}, 2'b01);
    chk("abort_diff", diff, 32'd0);
    chk("abort_bout", bout, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_no_result", out_valid, 1'b0);
    run_op("after_abort", 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);

    // Reset while holding a result in DONE.
    accept(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    wait_done(cyc);
    chk("done_rst_valid_before", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("done_rst_flags", {out_valid, in_ready}, 2'b01);
    chk("done_rst_diff", {bout, diff}, 33'd0);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (n % 5 == 0) ? ra : $urandom;
      run_op("random", ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
